// File: rtl/io_controller_pkg.sv
// Shared IO definitions: data width, 3-bit state codes (also decoded by the LCD driver), request bundle.
package io_controller_pkg;
    localparam int DATA_W = 32;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_WAIT_PRESS   = 3'd1;
    localparam logic [2:0] ST_WAIT_RELEASE = 3'd2;
    localparam logic [2:0] ST_DONE         = 3'd3;
    localparam logic [2:0] ST_HALTED       = 3'd4;

    typedef enum logic [2:0] {
        IDLE         = ST_IDLE,
        WAIT_PRESS   = ST_WAIT_PRESS,
        WAIT_RELEASE = ST_WAIT_RELEASE,
        DONE         = ST_DONE,
        HALTED       = ST_HALTED
    } io_state_e;

    typedef struct packed {
        logic halt;
        logic insert;
        logic out_write;
    } io_req_t;
endpackage

// File: rtl/io_controller_debounce.sv
// Confirm button conditioning: 2-flop synchronizer plus optional debounce (IO_DEBOUNCE_EN).
// rise/fall pulse in the cycle whose clock edge changes the accepted level.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync_q;
    logic       sync;

    always_ff @(posedge clock) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], raw};
    end
    assign sync = sync_q[1];

`ifdef IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          acc_q;
    logic          accept;

    // Accept on the edge that sees the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign accept = (sync != acc_q) && (cnt_q >= CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            acc_q <= sync;
        end else if (sync == acc_q) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = acc_q;
    assign rise  = accept &  sync;
    assign fall  = accept & ~sync;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = |DEBOUNCE_CYCLES;

    assign level = sync;
    assign rise  =  sync_q[0] & ~sync;
    assign fall  = ~sync_q[0] &  sync;
`endif
endmodule

// File: rtl/io_controller.sv
// IN/OUT/HALT handshake between the control unit and the board switches/button/display.
// Build option IO_DEBOUNCE_EN enables confirm debouncing in io_debounce.
module io_controller
    import io_controller_pkg::*;
#(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                isInsert,
    input  logic                outWrite,
    input  logic                isHalt,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                confirm,
    input  logic [DATA_W-1:0]   outData,
    output logic                ioStall,
    output logic [DATA_W-1:0]   insertData,
    output logic                insertValid,
    output logic [DATA_W-1:0]   displayData,
    output logic                displayValid,
    output logic                waitingInput,
    output logic                halted
);
    io_state_e         state_q, state_d;
    io_req_t           req;
    logic              btn_rise, btn_fall, btn_level_unused;
    logic              capture, show, stall;
    logic [DATA_W-1:0] insert_q, display_q;
    logic              display_vld_q;

    assign req = '{halt: isHalt, insert: isInsert, out_write: outWrite};

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
        .clock (clock),
        .reset (reset),
        .raw   (confirm),
        .level (btn_level_unused),
        .rise  (btn_rise),
        .fall  (btn_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        show    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req.halt | req.insert;
                if (req.halt)           state_d = HALTED;
                else if (req.insert)    state_d = WAIT_PRESS;
                else if (req.out_write) show    = 1'b1;
            end
            WAIT_PRESS: begin
                stall = 1'b1;
                if (btn_rise) begin
                    capture = 1'b1;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                stall = 1'b1;
                if (btn_fall) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            HALTED:  stall   = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            insert_q      <= '0;
            display_q     <= '0;
            display_vld_q <= 1'b0;
        end else begin
            if (capture) insert_q <= DATA_W'(switches);
            if (show) begin
                display_q     <= outData;
                display_vld_q <= 1'b1;
            end
        end
    end

    assign ioStall      = stall & ~reset;
    assign insertData   = insert_q;
    assign insertValid  = (state_q == DONE);
    assign displayData  = display_q;
    assign displayValid = display_vld_q;
    assign waitingInput = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
    assign halted       = (state_q == HALTED);
endmodule

// File: tb/tb_io_controller.sv
// Scoreboard bench for io_controller with DEBOUNCE_CYCLES=4.
module tb_io_controller;
    localparam int DB = 4;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        isInsert = 1'b0, outWrite = 1'b0, isHalt = 1'b0, confirm = 1'b0;
    logic [15:0] switches = '0;
    logic [31:0] outData = '0;
    logic        ioStall, insertValid, displayValid, waitingInput, halted;
    logic [31:0] insertData, displayData;

    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];

    io_controller #(.SW_WIDTH(16), .DEBOUNCE_CYCLES(DB)) dut (
        .clock(clock), .reset(reset), .isInsert(isInsert), .outWrite(outWrite),
        .isHalt(isHalt), .switches(switches), .confirm(confirm), .outData(outData),
        .ioStall(ioStall), .insertData(insertData), .insertValid(insertValid),
        .displayData(displayData), .displayValid(displayValid),
        .waitingInput(waitingInput), .halted(halted)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (insertValid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL insert_unexpected got=%h", insertData);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                if (insertData !== e) begin
                    errors++;
                    $display("FAIL insert_data got=%h exp=%h", insertData, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_insert(input logic [15:0] sw);
        switches = sw;
        isInsert = 1'b1;
        tick();
        isInsert = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; isInsert = 1'b1; isHalt = 1'b1;
        repeat (3) tick();
        checks++;
        if (ioStall !== 1'b0) begin errors++; $display("FAIL stall_in_reset got=%b exp=0", ioStall); end
        isInsert = 1'b0; isHalt = 1'b0; reset = 1'b0;
        #1;
        checks++;
        if ({insertData, displayData} !== 64'h0) begin
            errors++; $display("FAIL reset_data got=%h/%h exp=0/0", insertData, displayData);
        end
        checks++;
        if ({ioStall, insertValid, displayValid, waitingInput, halted} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000",
                               {ioStall, insertValid, displayValid, waitingInput, halted});
        end
        tick();
    endtask

    task automatic test_insert();
        int n = 0, bad = 0, idx = -1;
        switches = 16'hBEEF;
        isInsert = 1'b1;
        #1;
        checks++;
        if (ioStall !== 1'b1) begin errors++; $display("FAIL insert_req_stall got=%b exp=1", ioStall); end
        tick();
        isInsert = 1'b0;
        #1;
        checks++;
        if ({waitingInput, ioStall} !== 2'b11) begin
            errors++; $display("FAIL insert_waiting got=%b exp=11", {waitingInput, ioStall});
        end
        exp_q.push_back(32'h0000BEEF);
        confirm = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (n == 0 && insertData == 32'h0000BEEF) n = i + 1;
            if (ioStall !== 1'b1) bad++;
        end
        checks++;
        if (n != LAT) begin errors++; $display("FAIL press_latency got=%0d exp=%0d", n, LAT); end
        confirm = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (insertValid) begin idx = i + 1; break; end
            if (ioStall !== 1'b1) bad++;
        end
        checks++;
        if (idx != LAT) begin errors++; $display("FAIL release_latency got=%0d exp=%0d", idx, LAT); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_during_wait got=%0d drops exp=0", bad); end
        checks++;
        if (ioStall !== 1'b0) begin errors++; $display("FAIL done_stall got=%b exp=0", ioStall); end
        tick();
        checks++;
        if ({insertValid, waitingInput} !== 2'b00 || insertData !== 32'h0000BEEF) begin
            errors++; $display("FAIL after_done got=%b/%h exp=00/0000beef", {insertValid, waitingInput}, insertData);
        end
    endtask

    task automatic test_glitch();
`ifndef IO_DEBOUNCE_EN
        exp_q.push_back(32'h00001234);
`endif
        pulse_insert(16'h1234);
        confirm = 1'b1;
        repeat (3) tick();
        confirm = 1'b0;
        repeat (12) tick();
`ifdef IO_DEBOUNCE_EN
        checks++;
        if (waitingInput !== 1'b1 || insertData !== 32'h0000BEEF) begin
            errors++; $display("FAIL glitch_filtered got=%b/%h exp=1/0000beef", waitingInput, insertData);
        end
        exp_q.push_back(32'h00001234);
        confirm = 1'b1;
        repeat (10) tick();
        confirm = 1'b0;
        repeat (LAT + 4) tick();
`endif
        checks++;
        if (waitingInput !== 1'b0 || insertData !== 32'h00001234 || exp_q.size() != 0) begin
            errors++; $display("FAIL glitch_complete got=%b/%h/%0d exp=0/00001234/0",
                               waitingInput, insertData, exp_q.size());
        end
    endtask

    task automatic test_out();
        outData = 32'h12345678;
        outWrite = 1'b1;
        #1;
        checks++;
        if (ioStall !== 1'b0) begin errors++; $display("FAIL out_stall got=%b exp=0", ioStall); end
        tick();
        outWrite = 1'b0;
        checks++;
        if (displayData !== 32'h12345678 || displayValid !== 1'b1) begin
            errors++; $display("FAIL out_display got=%h/%b exp=12345678/1", displayData, displayValid);
        end
        outData = 32'hCAFEF00D;
        outWrite = 1'b1;
        tick();
        outWrite = 1'b0;
        checks++;
        if (displayData !== 32'hCAFEF00D) begin
            errors++; $display("FAIL out_update got=%h exp=cafef00d", displayData);
        end
    endtask

    task automatic test_halt();
        outData = 32'hDEADBEEF;
        isHalt = 1'b1; outWrite = 1'b1;
        #1;
        checks++;
        if (ioStall !== 1'b1) begin errors++; $display("FAIL halt_req_stall got=%b exp=1", ioStall); end
        tick();
        isHalt = 1'b0; outWrite = 1'b0;
        #1;
        checks++;
        if ({halted, ioStall} !== 2'b11 || displayData !== 32'hCAFEF00D) begin
            errors++; $display("FAIL halt_enter got=%b/%h exp=11/cafef00d", {halted, ioStall}, displayData);
        end
        pulse_insert(16'h5555);
        outWrite = 1'b1;
        confirm = 1'b1;
        repeat (10) tick();
        outWrite = 1'b0;
        confirm = 1'b0;
        repeat (10) tick();
        checks++;
        if ({halted, waitingInput} !== 2'b10 || insertData !== 32'h00001234 || displayData !== 32'hCAFEF00D) begin
            errors++; $display("FAIL halt_sticky got=%b/%h/%h exp=10/00001234/cafef00d",
                               {halted, waitingInput}, insertData, displayData);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({halted, ioStall, displayValid} !== 3'b000 || insertData !== 32'h0) begin
            errors++; $display("FAIL halt_reset got=%b/%h exp=000/0", {halted, ioStall, displayValid}, insertData);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        pulse_insert(16'h7777);
        confirm = 1'b1;
        repeat (LAT + 3) tick();
        checks++;
        if (waitingInput !== 1'b1 || insertData !== 32'h00007777) begin
            errors++; $display("FAIL midwait_capture got=%b/%h exp=1/00007777", waitingInput, insertData);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({ioStall, insertValid, waitingInput, halted, displayValid} !== 5'b0 || insertData !== 32'h0) begin
            errors++; $display("FAIL midwait_reset got=%b/%h exp=00000/0",
                               {ioStall, insertValid, waitingInput, halted, displayValid}, insertData);
        end
        reset = 1'b0;
        confirm = 1'b0;
        repeat (20) tick();
        checks++;
        if (waitingInput !== 1'b0 || insertData !== 32'h0) begin
            errors++; $display("FAIL midwait_idle got=%b/%h exp=0/0", waitingInput, insertData);
        end
    endtask

    task automatic test_held_press();
        int done_at = -1;
        confirm = 1'b1;
        repeat (10) tick();
        pulse_insert(16'hA5A5);
        repeat (15) tick();
        checks++;
        if (waitingInput !== 1'b1 || insertData !== 32'h0) begin
            errors++; $display("FAIL held_no_capture got=%b/%h exp=1/0", waitingInput, insertData);
        end
        confirm = 1'b0;
        repeat (15) tick();
        checks++;
        if (waitingInput !== 1'b1 || insertData !== 32'h0) begin
            errors++; $display("FAIL held_release got=%b/%h exp=1/0", waitingInput, insertData);
        end
        exp_q.push_back(32'h0000A5A5);
        confirm = 1'b1;
        repeat (10) tick();
        checks++;
        if (insertData !== 32'h0000A5A5) begin
            errors++; $display("FAIL held_second_press got=%h exp=0000a5a5", insertData);
        end
        confirm = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!waitingInput) begin done_at = i; break; end
        end
        tick();
        checks++;
        if (done_at < 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL held_complete got=%0d/%0d exp=done/0", done_at, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_insert();
        test_glitch();
        test_out();
        test_halt();
        test_reset_mid();
        test_held_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_controller.md
IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 SHALL have parameter SW_WIDTH, default 16: width of the switch input bank.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable cycles required before a button level change is accepted.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port isInsert, input, 1: control-unit IN request.
REQ-006 SHALL have port outWrite, input, 1: control-unit OUT request.
REQ-007 SHALL have port isHalt, input, 1: control-unit HALT request.
REQ-008 SHALL have port switches, input, SW_WIDTH: user data switches (asynchronous).
REQ-009 SHALL have port confirm, input, 1: raw confirm pushbutton, high = pressed (asynchronous).
REQ-010 SHALL have port outData, input, 32: register value to display.
REQ-011 SHALL have port ioStall, output, 1: hold PC / suppress writeback.
REQ-012 SHALL have port insertData, output, 32: captured switches, zero-extended.
REQ-013 SHALL have port insertValid, output, 1: one-cycle strobe; processor writes insertData to RT.
REQ-014 SHALL have port displayData, output, 32: last OUT value.
REQ-015 SHALL have port displayValid, output, 1: sticky; at least one OUT since reset.
REQ-016 SHALL have port waitingInput, output, 1: LED; waiting for user confirm.
REQ-017 SHALL have port halted, output, 1: processor halted.

Function
REQ-018 SHALL use the FSM states IDLE, WAIT_PRESS, WAIT_RELEASE, DONE and HALTED.
REQ-019 IDLE SHALL take requests by priority isHalt > isInsert > outWrite; the lower requests in the same cycle SHALL be ignored.
REQ-020 IDLE with isHalt SHALL go to HALTED; HALTED SHALL be left only by reset.
REQ-021 IDLE with isInsert SHALL go to WAIT_PRESS.
REQ-022 WAIT_PRESS SHALL go to WAIT_RELEASE on the accepted press edge and register {zeros, switches} into insertData on that edge.
REQ-023 WAIT_RELEASE SHALL go to DONE on the accepted release; DONE SHALL go to IDLE unconditionally after one cycle.
REQ-024 A press already held when WAIT_PRESS is entered SHALL NOT count; a release followed by a new press is required.
REQ-025 ioStall SHALL be combinational: 1 when (IDLE & (isInsert | isHalt)), WAIT_PRESS, WAIT_RELEASE or HALTED; 0 in DONE.
REQ-026 insertValid SHALL be 1 only in DONE; insertData SHALL hold its value until the next capture.
REQ-027 outWrite in IDLE without isHalt or isInsert SHALL register outData into displayData and set displayValid next cycle, with no stall.
REQ-028 outWrite SHALL be ignored in all states other than IDLE.
REQ-029 waitingInput SHALL be 1 in WAIT_PRESS and WAIT_RELEASE; halted SHALL be 1 in HALTED.
REQ-030 confirm SHALL pass through a 2-flop synchronizer before any use.
REQ-031 Press/release latency from a confirm edge SHALL be 2 + DEBOUNCE_CYCLES cycles with debounce, or 2 cycles without it.
REQ-032 The debounce counter SHALL clear whenever the synchronized level equals the accepted level, and SHALL not wrap (width clog2(DEBOUNCE_CYCLES)+1).

Reset
REQ-033 Reset SHALL return the FSM to IDLE from any state, including mid-wait or HALTED.
REQ-034 Reset SHALL clear all outputs, the synchronizer, the debounce counter and the accepted level (released).
REQ-035 With reset high, ioStall SHALL be 0 regardless of the request inputs.

Configuration
REQ-036 With IO_DEBOUNCE_EN defined, the accepted level SHALL change only after DEBOUNCE_CYCLES consecutive differing synchronized samples.
REQ-037 Without IO_DEBOUNCE_EN, the accepted level SHALL equal the synchronized level, and DEBOUNCE_CYCLES SHALL be unused.

Structure
REQ-038 The state encoding (3-bit localparams) and the data width 32 SHALL live in the shared io package/header, so the LCD driver can decode state.
REQ-039 The synchronizer plus debounce SHALL be a sub-module io_debounce (ports clock, reset, raw, level, rise, fall).

Verification (bench DEBOUNCE_CYCLES=4, debounce enabled)
REQ-040 isInsert pulse, switches=16'hBEEF, confirm high 10 cycles then low -> ioStall high throughout, waitingInput high, then a one-cycle insertValid with insertData=32'h0000BEEF and ioStall=0.
REQ-041 confirm glitch high 3 cycles during WAIT_PRESS -> state unchanged, no capture.
REQ-042 outWrite with outData=32'h12345678 in IDLE -> displayData=32'h12345678, displayValid=1 next cycle, ioStall=0.
REQ-043 isHalt and outWrite in the same cycle -> HALTED, halted=1, ioStall=1, displayData unchanged; presses ignored until reset.
REQ-044 reset asserted in WAIT_RELEASE -> IDLE next cycle, all outputs 0, no insertValid.
REQ-045 confirm held before isInsert -> no capture until release, then capture on the second press.
